// File: rtl/bram_arbiter_pkg.sv
// rtl/bram_arbiter_pkg.sv - shared types for the bram arbiter
// Contents:
//   bram_req_type   one bram access {valid, instr, addr, wdata, wstrb}
//   bram_owner_type which port owns the access in flight
//   arb_state_type  arbiter FSM states
package bram_arbiter_pkg;

    typedef struct packed {
        logic        valid;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bram_req_type;

    typedef enum logic {
        OWN_IMEM = 1'b0,
        OWN_DMEM = 1'b1
    } bram_owner_type;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_type;

endpackage

// File: rtl/bram_arb_slot.sv
// rtl/bram_arb_slot.sv - one-entry holding register for a request that lost arbitration
// Ports:
//   clock     in   rising-edge clock
//   reset     in   synchronous active-high reset, empties the slot
//   load      in   capture load_req (takes priority over clear)
//   clear     in   empty the slot once its request has been issued
//   load_req  in   request to capture
//   full      out  slot holds a request
//   req       out  held request; req.valid mirrors full
module bram_arb_slot
    import bram_arbiter_pkg::*;
(
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic         clear,
    input  bram_req_type load_req,
    output logic         full,
    output bram_req_type req
);

    bram_req_type data_q;

    // Only the valid bit needs resetting; the payload is ignored while empty.
    always_ff @(posedge clock) begin
        if (reset) begin
            data_q.valid <= 1'b0;
        end else if (load) begin
            data_q <= load_req;
        end else if (clear) begin
            data_q.valid <= 1'b0;
        end
    end

    assign full = data_q.valid;
    assign req  = data_q;

endmodule

// File: rtl/bram_arbiter.sv
// rtl/bram_arbiter.sv - shares a single-port 1-cycle bram between fetch (imem) and load/store (dmem)
// Optional feature macro: BRAM_ARB_RR_EN (round-robin on contention; DATA_PRIO ignored)
// Parameters:
//   DATA_PRIO   fixed contention priority: 1 = dmem wins, 0 = imem wins
// Ports:
//   clock, reset                      clock, synchronous active-high reset
//   imem_valid/addr                   fetch request pulse and byte address
//   imem_rdata/ready                  fetch data and completion pulse
//   dmem_valid/addr/wdata/wstrb       data request pulse; wstrb==0 is a load
//   dmem_rdata/ready                  load data and completion pulse (loads and stores)
//   bram_valid/instr/addr/wdata/wstrb access pulse to bram; instr=1 for fetches
//   bram_rdata/ready                  bram data and completion pulse one cycle after bram_valid
module bram_arbiter
    import bram_arbiter_pkg::*;
#(
    parameter bit DATA_PRIO = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        imem_valid,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_rdata,
    output logic        imem_ready,
    input  logic        dmem_valid,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic [31:0] dmem_rdata,
    output logic        dmem_ready,
    output logic        bram_valid,
    output logic        bram_instr,
    output logic [31:0] bram_addr,
    output logic [31:0] bram_wdata,
    output logic [3:0]  bram_wstrb,
    input  logic [31:0] bram_rdata,
    input  logic        bram_ready
);

    arb_state_type  state_q, state_d;
    bram_owner_type owner_q, owner_d;

    bram_req_type   imem_live, dmem_live;
    bram_req_type   imem_slot, dmem_slot;
    bram_req_type   imem_cand, dmem_cand;
    bram_req_type   issue_req;
    logic           imem_full, dmem_full;
    logic           imem_load, imem_clear;
    logic           dmem_load, dmem_clear;
    logic           window, contested, grant, prefer_dmem;
    bram_owner_type winner;

    always_comb begin
        imem_live       = '0;
        imem_live.valid = imem_valid;
        imem_live.instr = 1'b1;
        imem_live.addr  = imem_addr;

        dmem_live       = '0;
        dmem_live.valid = dmem_valid;
        dmem_live.instr = 1'b0;
        dmem_live.addr  = dmem_addr;
        dmem_live.wdata = dmem_wdata;
        dmem_live.wstrb = dmem_wstrb;
    end

    // A live pulse is preferred over the slot; both cannot coexist on one
    // port because each port keeps at most one request outstanding.
    always_comb begin
        imem_cand = '0;
        if (imem_valid) begin
            imem_cand = imem_live;
        end else if (imem_full) begin
            imem_cand = imem_slot;
        end

        dmem_cand = '0;
        if (dmem_valid) begin
            dmem_cand = dmem_live;
        end else if (dmem_full) begin
            dmem_cand = dmem_slot;
        end
    end

`ifdef BRAM_ARB_RR_EN
    // Remembers the last contested winner; the other port wins next time.
    bram_owner_type rr_last_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            rr_last_q <= OWN_IMEM;
        end else if (grant && contested) begin
            rr_last_q <= winner;
        end
    end

    assign prefer_dmem = (rr_last_q == OWN_IMEM);
`else
    assign prefer_dmem = DATA_PRIO;
`endif

    // Issue is allowed when idle, or in the cycle the previous access
    // completes so accesses can run back to back. Reset blocks issue.
    assign window    = !reset && ((state_q == ST_IDLE) || bram_ready);
    assign contested = imem_cand.valid && dmem_cand.valid;

    always_comb begin
        winner = OWN_IMEM;
        if (contested) begin
            winner = prefer_dmem ? OWN_DMEM : OWN_IMEM;
        end else if (dmem_cand.valid) begin
            winner = OWN_DMEM;
        end
    end

    assign issue_req = (winner == OWN_DMEM) ? dmem_cand : imem_cand;
    assign grant     = window && issue_req.valid;

    // A live request that is not issued this cycle parks in its slot; a
    // slot request that is issued leaves it.
    assign imem_load  = imem_valid && !(grant && (winner == OWN_IMEM));
    assign imem_clear = grant && (winner == OWN_IMEM) && !imem_valid;
    assign dmem_load  = dmem_valid && !(grant && (winner == OWN_DMEM));
    assign dmem_clear = grant && (winner == OWN_DMEM) && !dmem_valid;

    bram_arb_slot u_imem_slot (
        .clock    (clock),
        .reset    (reset),
        .load     (imem_load),
        .clear    (imem_clear),
        .load_req (imem_live),
        .full     (imem_full),
        .req      (imem_slot)
    );

    bram_arb_slot u_dmem_slot (
        .clock    (clock),
        .reset    (reset),
        .load     (dmem_load),
        .clear    (dmem_clear),
        .load_req (dmem_live),
        .full     (dmem_full),
        .req      (dmem_slot)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
            owner_q <= OWN_IMEM;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        if (window) begin
            if (grant) begin
                state_d = ST_BUSY;
                owner_d = winner;
            end else begin
                state_d = ST_IDLE;
            end
        end
    end

    assign bram_valid = grant;
    assign bram_instr = issue_req.instr;
    assign bram_addr  = issue_req.addr;
    assign bram_wdata = issue_req.wdata;
    assign bram_wstrb = issue_req.wstrb;

    // A bram_ready seen while idle is stale and is never forwarded; during
    // reset the in-flight response is dropped.
    assign imem_ready = !reset && bram_ready && (state_q == ST_BUSY) && (owner_q == OWN_IMEM);
    assign dmem_ready = !reset && bram_ready && (state_q == ST_BUSY) && (owner_q == OWN_DMEM);
    assign imem_rdata = bram_rdata;
    assign dmem_rdata = bram_rdata;

endmodule

// File: tb/tb_bram_arbiter.sv
// tb/tb_bram_arbiter.sv - self-checking bench for bram_arbiter
module tb_bram_arbiter;

    localparam bit DATA_PRIO = 1'b1;

    logic        clock;
    logic        reset;
    logic        imem_valid;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic        dmem_valid;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_rdata;
    logic        dmem_ready;
    logic        bram_valid;
    logic        bram_instr;
    logic [31:0] bram_addr;
    logic [31:0] bram_wdata;
    logic [3:0]  bram_wstrb;
    logic [31:0] bram_rdata;
    logic        bram_ready;

    int checks = 0;
    int errors = 0;

    bram_arbiter #(.DATA_PRIO(DATA_PRIO)) dut (
        .clock      (clock),
        .reset      (reset),
        .imem_valid (imem_valid),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ready (imem_ready),
        .dmem_valid (dmem_valid),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_wstrb (dmem_wstrb),
        .dmem_rdata (dmem_rdata),
        .dmem_ready (dmem_ready),
        .bram_valid (bram_valid),
        .bram_instr (bram_instr),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_wstrb (bram_wstrb),
        .bram_rdata (bram_rdata),
        .bram_ready (bram_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A00_0000 + 32'(i);
    endfunction

    // Behavioural bram: read-first, 1-cycle latency, word index addr[11:2].
    logic [31:0] bmem [0:1023];
    logic        mem_init;
    logic        ready_q;
    logic        stray;

    always @(posedge clock) begin
        ready_q <= bram_valid;
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) bmem[i] <= init_word(i);
        end else if (bram_valid) begin
            bram_rdata <= bmem[bram_addr[11:2]];
            for (int b = 0; b < 4; b++)
                if (bram_wstrb[b]) bmem[bram_addr[11:2]][8*b +: 8] <= bram_wdata[8*b +: 8];
        end
    end

    assign bram_ready = ready_q | stray;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
        stray = 1'b0;
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [31:0] da;
        logic [31:0] dwd;
        logic [3:0]  dws;
        logic        ebv;
        logic        einstr;
        logic [31:0] eaddr;
        logic [31:0] ewdata;
        logic [3:0]  ewstrb;
        logic        eir;
        logic        edr;
        logic        chk;
        logic [31:0] edata;
    } vec_t;

    vec_t vecs [9];

    // Random-phase reference model state
    logic [31:0] ref_mem [8];
    int          m_inf;
    logic [31:0] m_data;
    logic        m_load;
    logic        m_pi, m_pd, m_last_dmem, busy_i, busy_d;
    logic [31:0] m_ia, m_da, m_dwd;
    logic [3:0]  m_dws;

    initial begin
        vecs[0] = '{1'b1, 32'h100, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[1] = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 32'h5A000040};
        vecs[2] = '{1'b1, 32'h200, 1'b1, 32'h300, 32'h0, 4'h0, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[3] = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b1, 32'h200, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 32'h5A0000C0};
        vecs[4] = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 1'b1, 32'h5A000080};
        vecs[5] = '{1'b0, 32'h0, 1'b1, 32'h40, 32'hDEADBEEF, 4'b0011, 1'b1, 1'b0, 32'h40, 32'hDEADBEEF, 4'b0011, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[6] = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b0, 32'h0};
        vecs[7] = '{1'b0, 32'h0, 1'b1, 32'h40, 32'h0, 4'h0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0, 1'b0, 1'b0, 1'b0, 32'h0};
        vecs[8] = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 1'b1, 32'h5A00BEEF};

        reset = 1'b1;
        mem_init = 1'b1;
        stray = 1'b0;
        imem_valid = 1'b0;
        imem_addr = 32'h0;
        dmem_valid = 1'b0;
        dmem_addr = 32'h0;
        dmem_wdata = 32'h0;
        dmem_wstrb = 4'h0;
        @(posedge clock); #1;
        mem_init = 1'b0;
        #1;
        check("reset_imem_ready", imem_ready, 1'b0);
        check("reset_dmem_ready", dmem_ready, 1'b0);
        check("reset_bram_valid", bram_valid, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        #1;
        check("post_reset_bram_valid", bram_valid, 1'b0);
        check("post_reset_imem_ready", imem_ready, 1'b0);

        // Directed table: single fetch, contention, store then load-back.
        for (int v = 0; v < 9; v++) begin
            imem_valid = vecs[v].iv;
            imem_addr  = vecs[v].ia;
            dmem_valid = vecs[v].dv;
            dmem_addr  = vecs[v].da;
            dmem_wdata = vecs[v].dwd;
            dmem_wstrb = vecs[v].dws;
            #1;
            check($sformatf("vec%0d_bram_valid", v), bram_valid, vecs[v].ebv);
            check($sformatf("vec%0d_imem_ready", v), imem_ready, vecs[v].eir);
            check($sformatf("vec%0d_dmem_ready", v), dmem_ready, vecs[v].edr);
            if (vecs[v].ebv) begin
                check($sformatf("vec%0d_bram_instr", v), bram_instr, vecs[v].einstr);
                check($sformatf("vec%0d_bram_addr", v), bram_addr, vecs[v].eaddr);
                check($sformatf("vec%0d_bram_wdata", v), bram_wdata, vecs[v].ewdata);
                check($sformatf("vec%0d_bram_wstrb", v), bram_wstrb, vecs[v].ewstrb);
            end
            if (vecs[v].chk) begin
                if (vecs[v].edr) check($sformatf("vec%0d_dmem_rdata", v), dmem_rdata, vecs[v].edata);
                else             check($sformatf("vec%0d_imem_rdata", v), imem_rdata, vecs[v].edata);
            end
            @(posedge clock); #1;
        end
        imem_valid = 1'b0;
        dmem_valid = 1'b0;

        // Continuous contention: who is served first each round.
        do_reset();
        for (int r = 0; r < 8; r++) begin
            logic exp_dmem;
`ifdef BRAM_ARB_RR_EN
            exp_dmem = (r % 2 == 0);
`else
            exp_dmem = DATA_PRIO;
`endif
            imem_valid = 1'b1;
            imem_addr  = 32'h100;
            dmem_valid = 1'b1;
            dmem_addr  = 32'h300;
            dmem_wstrb = 4'h0;
            #1;
            check($sformatf("cont%0d_first_instr", r), bram_instr, !exp_dmem);
            @(posedge clock); #1;
            imem_valid = 1'b0;
            dmem_valid = 1'b0;
            #1;
            check($sformatf("cont%0d_first_dready", r), dmem_ready, exp_dmem);
            check($sformatf("cont%0d_first_iready", r), imem_ready, !exp_dmem);
            @(posedge clock); #1;
            #1;
            check($sformatf("cont%0d_second_dready", r), dmem_ready, !exp_dmem);
            check($sformatf("cont%0d_second_iready", r), imem_ready, exp_dmem);
            @(posedge clock); #1;
        end

        // Reset the cycle after a contested grant, then a stale bram_ready.
        do_reset();
        imem_valid = 1'b1;
        imem_addr  = 32'h200;
        dmem_valid = 1'b1;
        dmem_addr  = 32'h300;
        dmem_wstrb = 4'h0;
        #1;
        check("rst_grant_bram_valid", bram_valid, 1'b1);
        @(posedge clock); #1;
        reset = 1'b1;
        imem_valid = 1'b0;
        dmem_valid = 1'b0;
        #1;
        check("rst_mid_imem_ready", imem_ready, 1'b0);
        check("rst_mid_dmem_ready", dmem_ready, 1'b0);
        check("rst_mid_bram_valid", bram_valid, 1'b0);
        @(posedge clock); #1;
        reset = 1'b0;
        stray = 1'b1;
        #1;
        check("rst_after_imem_ready", imem_ready, 1'b0);
        check("rst_after_dmem_ready", dmem_ready, 1'b0);
        check("rst_after_slot_empty", bram_valid, 1'b0);
        @(posedge clock); #1;
        stray = 1'b0;
        imem_valid = 1'b1;
        imem_addr  = 32'h100;
        #1;
        check("rst_new_bram_valid", bram_valid, 1'b1);
        @(posedge clock); #1;
        imem_valid = 1'b0;
        #1;
        check("rst_new_imem_ready", imem_ready, 1'b1);
        check("rst_new_imem_rdata", imem_rdata, 32'h5A000040);
        check("rst_new_dmem_ready", dmem_ready, 1'b0);
        @(posedge clock); #1;

        // Random single-outstanding traffic against a request-level model.
        do_reset();
        for (int i = 0; i < 8; i++) ref_mem[i] = init_word(i);
        m_inf = 0; m_data = 32'h0; m_load = 1'b0;
        m_pi = 1'b0; m_pd = 1'b0; m_last_dmem = 1'b0;
        busy_i = 1'b0; busy_d = 1'b0;
        m_ia = 32'h0; m_da = 32'h0; m_dwd = 32'h0; m_dws = 4'h0;
        for (int cyc = 0; cyc < 1504; cyc++) begin
            logic        e_ir, e_dr, e_bv, e_instr, e_load;
            logic [31:0] e_data, e_addr, e_wdata;
            logic [3:0]  e_wstrb;
            int          w;
            imem_valid = 1'b0;
            dmem_valid = 1'b0;
            if (cyc < 1500 && !busy_i && $urandom_range(0, 2) != 0) begin
                imem_valid = 1'b1;
                imem_addr  = $urandom() & 32'hFFFF_F01C;
            end
            if (cyc < 1500 && !busy_d && $urandom_range(0, 2) != 0) begin
                dmem_valid = 1'b1;
                dmem_addr  = $urandom() & 32'hFFFF_F01C;
                dmem_wdata = $urandom();
                dmem_wstrb = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            end

            e_ir = (m_inf == 1);
            e_dr = (m_inf == 2);
            e_data = m_data;
            e_load = m_load;

            if (imem_valid) begin
                m_pi = 1'b1; m_ia = imem_addr; busy_i = 1'b1;
            end
            if (dmem_valid) begin
                m_pd = 1'b1; m_da = dmem_addr; m_dwd = dmem_wdata; m_dws = dmem_wstrb; busy_d = 1'b1;
            end

            w = 0;
            if (m_pi && m_pd) begin
`ifdef BRAM_ARB_RR_EN
                w = m_last_dmem ? 1 : 2;
                m_last_dmem = (w == 2);
`else
                w = DATA_PRIO ? 2 : 1;
`endif
            end else if (m_pi) begin
                w = 1;
            end else if (m_pd) begin
                w = 2;
            end

            e_bv = (w != 0);
            e_instr = 1'b0; e_addr = 32'h0; e_wdata = 32'h0; e_wstrb = 4'h0;
            if (w == 1) begin
                e_instr = 1'b1;
                e_addr  = m_ia;
                m_pi    = 1'b0;
                m_data  = ref_mem[m_ia[4:2]];
                m_load  = 1'b1;
            end else if (w == 2) begin
                e_addr  = m_da;
                e_wdata = m_dwd;
                e_wstrb = m_dws;
                m_pd    = 1'b0;
                m_data  = ref_mem[m_da[4:2]];
                m_load  = (m_dws == 4'h0);
                for (int b = 0; b < 4; b++)
                    if (m_dws[b]) ref_mem[m_da[4:2]][8*b +: 8] = m_dwd[8*b +: 8];
            end
            m_inf = w;

            #1;
            check("rnd_imem_ready", imem_ready, e_ir);
            check("rnd_dmem_ready", dmem_ready, e_dr);
            check("rnd_bram_valid", bram_valid, e_bv);
            if (e_ir) check("rnd_imem_rdata", imem_rdata, e_data);
            if (e_dr && e_load) check("rnd_dmem_rdata", dmem_rdata, e_data);
            if (e_bv) begin
                check("rnd_bram_instr", bram_instr, e_instr);
                check("rnd_bram_addr", bram_addr, e_addr);
                check("rnd_bram_wdata", bram_wdata, e_wdata);
                check("rnd_bram_wstrb", bram_wstrb, e_wstrb);
            end
            if (e_ir) busy_i = 1'b0;
            if (e_dr) busy_d = 1'b0;
            @(posedge clock); #1;
        end
        check("rnd_drained", {30'h0, busy_i, busy_d}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
